// File: rtl/alu_flag_writeback_pkg.sv
// Shared execute-stage definitions: condition encodings, NZCV bit positions,
// write-queue entry type and the condition evaluator also used by the branch unit.
package exec_defs;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int WB_AW = 4;
  localparam int WB_DW = 32;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, p;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    p = 1'b0;
    case (cond)
      COND_EQ: p = z;
      COND_NE: p = ~z;
      COND_CS: p = c;
      COND_CC: p = ~c;
      COND_MI: p = n;
      COND_PL: p = ~n;
      COND_VS: p = v;
      COND_VC: p = ~v;
      COND_HI: p = c & ~z;
      COND_LS: p = ~c | z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = ~z & (n == v);
      COND_LE: p = z | (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/alu_flag_writeback_if.sv
// ALU-to-writeback and writeback-to-register-file signal bundle.
// master = ALU / register-file side, slave = alu_flag_writeback.
interface alu_flag_writeback_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_cond;
  logic          in_s;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_result;
  logic          in_n;
  logic          in_z;
  logic          in_c;
  logic          in_v;
  logic          in_wb;
  logic [3:0]    flags_nzcv;
  logic          rf_valid;
  logic          rf_ready;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output in_valid, in_cond, in_s, in_rd, in_result, in_n, in_z, in_c, in_v, in_wb,
    output rf_ready,
    input  in_ready, flags_nzcv, rf_valid, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_cond, in_s, in_rd, in_result, in_n, in_z, in_c, in_v, in_wb,
    input  rf_ready,
    output in_ready, flags_nzcv, rf_valid, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/alu_flag_writeback_wb_fifo.sv
// Register-write queue. Head output holds the last popped entry while empty
// so the register-file write bus does not glitch between writes.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  last_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_flag_writeback.sv
// Execute-stage back end: NZCV flag register, condition check, write queue.
// Optional COND_STATS_EN adds exec_cnt / squash_cnt counters.
module alu_flag_writeback
  import exec_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_flag_writeback_if.slave  bus
`ifdef COND_STATS_EN
  ,
  output logic [31:0]          exec_cnt,
  output logic [31:0]          squash_cnt
`endif
);

  logic [3:0]       flags_q;
  logic             pass;
  logic             accept;
  logic             do_flags;
  logic             do_push;
  logic             do_pop;
  logic [AW+DW-1:0] q_dout;
  logic             q_full;
  logic             q_empty;
  logic [CW-1:0]    q_count;

  // Condition is evaluated against the flags before this instruction's own update.
  always_comb begin
    pass     = cond_pass(bus.in_cond, flags_q);
    accept   = bus.in_valid & bus.in_ready;
    do_flags = accept & pass & (bus.in_s | ~bus.in_wb);
    do_push  = accept & pass & bus.in_wb & ~q_full;
    do_pop   = ~q_empty & bus.rf_ready;
  end

  assign bus.in_ready   = (q_count != CW'(DEPTH));
  assign bus.flags_nzcv = flags_q;
  assign bus.rf_valid   = ~q_empty;
  assign {bus.rf_waddr, bus.rf_wdata} = q_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (do_flags) begin
      flags_q <= {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_wb_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .din   ({bus.in_rd, bus.in_result}),
    .pop   (do_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

`ifdef COND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (accept) begin
      if (pass) exec_cnt   <= exec_cnt + 1'b1;
      else      squash_cnt <= squash_cnt + 1'b1;
    end
  end
`endif

endmodule
